memory_arbiter: RTL

Sits directly downstream of the request unit and the fetch path, between the CPU datapath and the single-port RAM. Accepts independent instruction-read and data-read/write requests, serializes them onto one RAM port with a registered command and response, and returns single-cycle `ihit`/`dhit` pulses with the loaded word. Adds fair alternation between request sources, a busy watchdog and a sticky error flag.

---
 rtl/cpu_types_pkg.sv | 32 +++
 rtl/arbiter_if.sv | 44 ++++
 rtl/arb_watchdog.sv | 43 ++++
 rtl/memory_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: data word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DACC  = 3'd1,
        IACC  = 3'd2,
        DRESP = 3'd3,
        IRESP = 3'd4
    } arb_state_t;

    localparam logic SRC_INSTR = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    function automatic logic is_acc_state(input arb_state_t s);
        return (s == DACC) || (s == IACC);
    endfunction

    function automatic logic ram_waiting(input ramstate_t r);
        return (r == FREE) || (r == BUSY);
    endfunction

endpackage

// File: rtl/arbiter_if.sv
// Port bundle between the CPU-side requesters, the arbiter and the RAM model.
// The stats signals exist only when ARB_STATS_EN is defined.
interface arbiter_if;
    import cpu_types_pkg::*;

    logic      iren;
    word_t     iaddr;
    logic      dren;
    logic      dwen;
    word_t     daddr;
    word_t     dstore;
    logic      ihit;
    word_t     iload;
    logic      dhit;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      memerr;
`ifdef ARB_STATS_EN
    logic [31:0] icount;
    logic [31:0] dcount;
    logic [15:0] errcount;
`endif

    modport arb (
        input  iren, iaddr, dren, dwen, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
`ifdef ARB_STATS_EN
        , output icount, dcount, errcount
`endif
    );

    modport tb (
        output iren, iaddr, dren, dwen, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
`ifdef ARB_STATS_EN
        , input icount, dcount, errcount
`endif
    );
endinterface

// File: rtl/arb_watchdog.sv
// Busy watchdog: counts waiting cycles inside a RAM access and flags the cycle
// in which the count reaches TIMEOUT.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = $clog2(TIMEOUT + 32'd1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 32'd1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // next count: clear outside accesses, advance on each waiting cycle
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // expiry when this waiting cycle brings the count up to TIMEOUT
    always_comb begin
        expired_o = en_i && !clr_i && (count_q == LIMIT);
    end

    // counter register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/memory_arbiter.sv
// Serializes instruction and data requests onto one RAM port with fair alternation,
// a busy watchdog and sticky error. Define ARB_STATS_EN to add completion/error counters.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iren,
    input  word_t       iaddr,
    input  logic        dren,
    input  logic        dwen,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        ihit,
    output word_t       iload,
    output logic        dhit,
    output word_t       dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  ramstate_t   ramstate,
`ifdef ARB_STATS_EN
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [15:0] errcount,
`endif
    output logic        memerr
);
    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       ihit_q, ihit_d;
    logic       dhit_q, dhit_d;
    word_t      iload_q, iload_d;
    word_t      dload_q, dload_d;
    logic       ren_q, ren_d;
    logic       wen_q, wen_d;
    word_t      addr_q, addr_d;
    word_t      store_q, store_d;
    logic       memerr_q, memerr_d;

    logic       d_pend_s;
    logic       pick_data_s;
    logic       in_acc_s;
    logic       wd_en_s;
    logic       wd_expired_s;
    logic       abort_s;

    // request decode and arbitration; data wins a tie unless it was served last
    always_comb begin
        d_pend_s    = dren || dwen;
        pick_data_s = d_pend_s && (!iren || (last_q == SRC_INSTR));
        in_acc_s    = is_acc_state(state_q);
        wd_en_s     = in_acc_s && ram_waiting(ramstate);
        abort_s     = in_acc_s && ((ramstate == ERROR) || wd_expired_s);
    end

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .CLK       (CLK),
        .nRST      (nRST),
        .clr_i     (!in_acc_s),
        .en_i      (wd_en_s),
        .expired_o (wd_expired_s)
    );

    // FSM next state and registered-output next values
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        ihit_d   = 1'b0;
        dhit_d   = 1'b0;
        iload_d  = iload_q;
        dload_d  = dload_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        store_d  = store_q;
        memerr_d = memerr_q;
        case (state_q)
            IDLE: begin
                if (pick_data_s) begin
                    state_d = DACC;
                    ren_d   = !dwen;
                    wen_d   = dwen;
                    addr_d  = daddr;
                    store_d = dwen ? dstore : 32'h0000_0000;
                end else if (iren) begin
                    state_d = IACC;
                    ren_d   = 1'b1;
                    wen_d   = 1'b0;
                    addr_d  = iaddr;
                    store_d = 32'h0000_0000;
                end else begin
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    addr_d  = 32'h0000_0000;
                    store_d = 32'h0000_0000;
                end
            end
            DACC, IACC: begin
                if (ramstate == ACCESS) begin
                    if (state_q == IACC) begin
                        iload_d = ramload;
                        ihit_d  = 1'b1;
                        state_d = IRESP;
                    end else begin
                        dload_d = wen_q ? dload_q : ramload;
                        dhit_d  = 1'b1;
                        state_d = DRESP;
                    end
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    addr_d  = 32'h0000_0000;
                    store_d = 32'h0000_0000;
                end else if (abort_s) begin
                    memerr_d = 1'b1;
                    state_d  = IDLE;
                    ren_d    = 1'b0;
                    wen_d    = 1'b0;
                    addr_d   = 32'h0000_0000;
                    store_d  = 32'h0000_0000;
                end else begin
                    state_d = state_q;
                end
            end
            DRESP: begin
                state_d = IDLE;
                last_d  = SRC_DATA;
            end
            IRESP: begin
                state_d = IDLE;
                last_d  = SRC_INSTR;
            end
            default: begin
                state_d = IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
                addr_d  = 32'h0000_0000;
                store_d = 32'h0000_0000;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            last_q   <= SRC_INSTR;
            ihit_q   <= 1'b0;
            dhit_q   <= 1'b0;
            iload_q  <= 32'h0000_0000;
            dload_q  <= 32'h0000_0000;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= 32'h0000_0000;
            store_q  <= 32'h0000_0000;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            ihit_q   <= ihit_d;
            dhit_q   <= dhit_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            memerr_q <= memerr_d;
        end
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign memerr   = memerr_q;

`ifdef ARB_STATS_EN
    logic [31:0] icount_q, icount_d;
    logic [31:0] dcount_q, dcount_d;
    logic [15:0] errcount_q, errcount_d;

    // completion counters wrap; the abort counter saturates
    always_comb begin
        icount_d   = icount_q + 32'(ihit_q);
        dcount_d   = dcount_q + 32'(dhit_q);
        errcount_d = errcount_q;
        if (abort_s && (errcount_q != 16'hFFFF)) begin
            errcount_d = errcount_q + 16'd1;
        end else begin
            errcount_d = errcount_q;
        end
    end

    // statistics registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount_q   <= 32'h0000_0000;
            dcount_q   <= 32'h0000_0000;
            errcount_q <= 16'h0000;
        end else begin
            icount_q   <= icount_d;
            dcount_q   <= dcount_d;
            errcount_q <= errcount_d;
        end
    end

    assign icount   = icount_q;
    assign dcount   = dcount_q;
    assign errcount = errcount_q;
`endif
endmodule
